// File: rtl/sumsub_pkg.sv
// rtl/sumsub_pkg.sv - shared dual-rail encodings, FSM states and helpers for sumsub_serial_dr
//
// Purpose: dual-rail pair constants, the controller state enum and small
//          encode/decode/legality helpers used by the cell and the top level.
// Ports:   none (package).
package sumsub_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_1 : DR_0;
  endfunction

  // Only a legal logic-1 pair decodes to 1; NULL and illegal read as 0.
  function automatic logic dr_decode(input logic [1:0] p);
    return p[1] & ~p[0];
  endfunction

  function automatic logic dr_legal(input logic [1:0] p);
    return p[1] ^ p[0];
  endfunction

endpackage

// File: rtl/dr_sumsub_cell.sv
// rtl/dr_sumsub_cell.sv - one logical bit of dual-rail add/subtract
//
// Purpose: full adder on dual-rail pairs with B optionally inverted by op.
// Ports:
//   a, b, op, cin  in  2  dual-rail operand bits, mode and carry in
//   sum, cout      out 2  dual-rail sum and carry out; NULL if any input
//                         pair is not a legal 01/10 code
module dr_sumsub_cell
  import sumsub_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  input  logic [1:0] cin,
  output logic [1:0] sum,
  output logic [1:0] cout
);

  logic all_ok;
  logic av, bv, cv;

  always_comb begin
    all_ok = dr_legal(a) & dr_legal(b) & dr_legal(op) & dr_legal(cin);
    av     = dr_decode(a);
    bv     = dr_decode(b) ^ dr_decode(op);
    cv     = dr_decode(cin);
    sum    = DR_NULL;
    cout   = DR_NULL;
    // Without complete operands the cell stays NULL rather than guessing.
    if (all_ok) begin
      sum  = dr_encode(av ^ bv ^ cv);
      cout = dr_encode((av & bv) | (av & cv) | (bv & cv));
    end
  end

endmodule

// File: rtl/sumsub_serial_dr.sv
// rtl/sumsub_serial_dr.sv - digit-serial dual-rail add/subtract engine
//
// Purpose: computes A + (B ^ op) + carry_in over WIDTH/DIGIT cycles, DIGIT
//          bits per cycle, with a dual-rail carry register between cycles.
// Ports:
//   clk, rst              in   clock; synchronous active-high reset
//   in_valid / in_ready   in/out  operand handshake (ready only in IDLE)
//   A, B                  in   2*WIDTH dual-rail operands (bit i at [2i+1:2i])
//   op, carry_in          in   2 dual-rail mode (1 = subtract) and carry in
//   out_valid / out_ready out/in  result handshake
//   out, carry_out        out  dual-rail result and MSB carry (NULL when idle)
//   ovf, zero             out  signed overflow and result-is-zero flags
//   err                   out  one-cycle pulse on a discarded illegal transfer
module sumsub_serial_dr
  import sumsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] A,
  input  logic [2*WIDTH-1:0] B,
  input  logic [1:0]         op,
  input  logic [1:0]         carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic [1:0]         carry_out,
  output logic               ovf,
  output logic               zero,
  output logic               err
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * WIDTH;
  localparam int D2 = 2 * DIGIT;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("sumsub_serial_dr: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   a_sh, b_sh, res_sh, res_next;
  logic [1:0]      op_r, carry_r, msb_cin_r;
  logic            err_r;
  logic            in_legal, zero_all;
  logic [D2-1:0]   sum_digit;
  logic [D2+1:0]   chain;

  // Every pair of every input must be 01/10 for a transfer to be accepted.
  always_comb begin
    in_legal = dr_legal(op) & dr_legal(carry_in);
    for (int i = 0; i < WIDTH; i++) begin
      in_legal = in_legal & dr_legal(A[2*i +: 2]) & dr_legal(B[2*i +: 2]);
    end
  end

  // Ripple chain for the current digit: low DIGIT pairs of the shifters.
  assign chain[1:0] = carry_r;

  genvar g;
  generate
    for (g = 0; g < DIGIT; g++) begin : g_cell
      dr_sumsub_cell u_cell (
        .a    (a_sh[2*g +: 2]),
        .b    (b_sh[2*g +: 2]),
        .op   (op_r),
        .cin  (chain[2*g +: 2]),
        .sum  (sum_digit[2*g +: 2]),
        .cout (chain[2*g+2 +: 2])
      );
    end
  endgenerate

  // Result digits enter at the top, so after N cycles digit 0 sits at bit 0.
  always_comb begin
    res_next            = res_sh >> D2;
    res_next[W2-1 -: D2] = sum_digit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      op_r      <= DR_NULL;
      carry_r   <= DR_NULL;
      msb_cin_r <= DR_NULL;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_legal) begin
              a_sh    <= A;
              b_sh    <= B;
              op_r    <= op;
              carry_r <= carry_in;
              cnt     <= '0;
              state   <= ST_RUN;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          a_sh      <= a_sh >> D2;
          b_sh      <= b_sh >> D2;
          res_sh    <= res_next;
          carry_r   <= chain[D2 +: 2];
          // Carry into the last cell; on the final digit this feeds ovf.
          msb_cin_r <= chain[D2-2 +: 2];
          if (cnt == CW'(N - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    zero_all = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      zero_all = zero_all & (res_sh[2*i +: 2] == DR_0);
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out       = out_valid ? res_sh : '0;
  assign carry_out = out_valid ? carry_r : DR_NULL;
  assign ovf       = out_valid & (dr_decode(msb_cin_r) ^ dr_decode(carry_r));
  assign zero      = out_valid & zero_all;
  assign err       = err_r;

endmodule

// File: tb/tb_sumsub_serial_dr.sv
// tb/tb_sumsub_serial_dr.sv - directed self-checking bench for sumsub_serial_dr
module tb_sumsub_serial_dr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8, DIGIT=2 instance
  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready8, out_valid8, ovf8, zero8, err8;
  logic [15:0] a8 = '0, b8 = '0, out8;
  logic [1:0]  op8 = 2'b01, cin8 = 2'b01, co8;

  // WIDTH=32, DIGIT=4 instance
  logic        in_valid32 = 1'b0, out_ready32 = 1'b1;
  logic        in_ready32, out_valid32, ovf32, zero32, err32;
  logic [63:0] a32 = '0, b32 = '0, out32;
  logic [1:0]  op32 = 2'b01, cin32 = 2'b01, co32;

  int n_cmp = 0;
  int n_bad = 0;

  sumsub_serial_dr #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .op(op8), .carry_in(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
    .carry_out(co8), .ovf(ovf8), .zero(zero8), .err(err8)
  );

  sumsub_serial_dr #(.WIDTH(32), .DIGIT(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .op(op32), .carry_in(cin32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out(out32),
    .carry_out(co32), .ovf(ovf32), .zero(zero32), .err(err32)
  );

  function automatic logic [15:0] dr8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [63:0] dr32(input logic [31:0] v);
    logic [63:0] r;
    for (int i = 0; i < 32; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] drb(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one transfer for exactly one edge; returns just after that edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic o, input logic c);
    a8 = dr8(a); b8 = dr8(b); op8 = drb(o); cin8 = drb(c);
    in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
  endtask

  // Waits (bounded) for out_valid8; lat is edges after the accept edge.
  task automatic wait8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
    n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
    n_cmp++; if (out8 !== 16'h0000) begin n_bad++; $display("FAIL reset_out got %h want 0000", out8); end
    n_cmp++; if ({co8, ovf8, zero8, err8} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", {co8, ovf8, zero8, err8}); end
    n_cmp++; if ({in_ready32, out_valid32, err32} !== 3'b100) begin n_bad++; $display("FAIL reset_w32 got %b want 100", {in_ready32, out_valid32, err32}); end
  endtask

  task automatic test_add();
    int lat;
    out_ready8 = 1'b1;
    issue8(8'h5A, 8'h3C, 1'b0, 1'b0);
    n_cmp++; if (in_ready8 !== 1'b0) begin n_bad++; $display("FAIL add_busy got in_ready=%b want 0", in_ready8); end
    wait8(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL add_latency got %0d want 4", lat); end
    n_cmp++; if (out8 !== dr8(8'h96)) begin n_bad++; $display("FAIL add_out got %h want %h", out8, dr8(8'h96)); end
    n_cmp++; if ({co8, ovf8, zero8, err8} !== 5'b01_1_0_0) begin n_bad++; $display("FAIL add_flags got %b want 01100", {co8, ovf8, zero8, err8}); end
    step();
    n_cmp++; if ({in_ready8, out_valid8, out8, co8} !== {1'b1, 1'b0, 16'h0, 2'b00}) begin n_bad++; $display("FAIL add_release got rdy=%b vld=%b out=%h co=%b want 1 0 0000 00", in_ready8, out_valid8, out8, co8); end
  endtask

  task automatic test_sub();
    int lat;
    issue8(8'h10, 8'h20, 1'b1, 1'b1);
    wait8(lat);
    n_cmp++; if (out_valid8 !== 1'b1) begin n_bad++; $display("FAIL sub1_valid got %b want 1", out_valid8); end
    n_cmp++; if (out8 !== dr8(8'hF0)) begin n_bad++; $display("FAIL sub1_out got %h want %h", out8, dr8(8'hF0)); end
    n_cmp++; if ({co8, ovf8, zero8} !== 4'b01_0_0) begin n_bad++; $display("FAIL sub1_flags got %b want 0100", {co8, ovf8, zero8}); end
    step();
    issue8(8'h80, 8'h01, 1'b1, 1'b1);
    wait8(lat);
    n_cmp++; if (out8 !== dr8(8'h7F)) begin n_bad++; $display("FAIL sub2_out got %h want %h", out8, dr8(8'h7F)); end
    n_cmp++; if ({out_valid8, co8, ovf8, zero8} !== 5'b1_10_1_0) begin n_bad++; $display("FAIL sub2_flags got %b want 11010", {out_valid8, co8, ovf8, zero8}); end
    step();
  endtask

  task automatic test_zero();
    int lat;
    issue8(8'h7F, 8'h81, 1'b0, 1'b0);
    wait8(lat);
    n_cmp++; if (out8 !== 16'h5555) begin n_bad++; $display("FAIL zero_out got %h want 5555", out8); end
    n_cmp++; if ({out_valid8, co8, ovf8, zero8} !== 5'b1_10_0_1) begin n_bad++; $display("FAIL zero_flags got %b want 11001", {out_valid8, co8, ovf8, zero8}); end
    step();
  endtask

  task automatic test_illegal();
    int lat;
    int seen;
    a8 = dr8(8'h00); a8[7:6] = 2'b11;
    b8 = dr8(8'h00); op8 = 2'b01; cin8 = 2'b01;
    in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    n_cmp++; if ({err8, in_ready8, out_valid8} !== 3'b110) begin n_bad++; $display("FAIL ill_err got err/rdy/vld=%b want 110", {err8, in_ready8, out_valid8}); end
    step();
    n_cmp++; if (err8 !== 1'b0) begin n_bad++; $display("FAIL ill_pulse got err=%b want 0", err8); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid8 || !in_ready8) seen++;
      step();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL ill_no_run got %0d busy cycles want 0", seen); end
    // NULL mode pair is rejected the same way.
    a8 = dr8(8'h01); b8 = dr8(8'h02); op8 = 2'b00;
    in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    n_cmp++; if ({err8, in_ready8} !== 2'b11) begin n_bad++; $display("FAIL ill_null_op got err/rdy=%b want 11", {err8, in_ready8}); end
    step();
    issue8(8'h10, 8'h20, 1'b1, 1'b1);
    wait8(lat);
    n_cmp++; if ({out_valid8, err8, out8} !== {1'b1, 1'b0, dr8(8'hF0)}) begin n_bad++; $display("FAIL ill_recover got vld=%b err=%b out=%h want 1 0 %h", out_valid8, err8, out8, dr8(8'hF0)); end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready8 = 1'b0;
    issue8(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait8(lat);
    // Offer a new transfer while DONE; it must not be taken.
    a8 = dr8(8'h01); b8 = dr8(8'h01); op8 = 2'b01; cin8 = 2'b01;
    in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid8, in_ready8, out8, co8, ovf8, zero8} !== {1'b1, 1'b0, dr8(8'h96), 2'b01, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b out=%h co=%b ovf=%b z=%b", i, out_valid8, in_ready8, out8, co8, ovf8, zero8);
      end
      step();
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    step();
    n_cmp++; if ({in_ready8, out_valid8} !== 2'b10) begin n_bad++; $display("FAIL bp_release got rdy/vld=%b want 10", {in_ready8, out_valid8}); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    int lat;
    issue8(8'h5A, 8'h3C, 1'b0, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({in_ready8, out_valid8, out8, co8} !== {1'b1, 1'b0, 16'h0, 2'b00}) begin n_bad++; $display("FAIL rst_mid got rdy=%b vld=%b out=%h co=%b want 1 0 0000 00", in_ready8, out_valid8, out8, co8); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid8) seen++;
      step();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_no_result got %0d valid cycles want 0", seen); end
    issue8(8'h7F, 8'h81, 1'b0, 1'b0);
    wait8(lat);
    n_cmp++; if ({out_valid8, out8, zero8} !== {1'b1, 16'h5555, 1'b1}) begin n_bad++; $display("FAIL rst_mid_recover got vld=%b out=%h z=%b", out_valid8, out8, zero8); end
    step();
  endtask

  task automatic test_add_w32();
    int lat;
    a32 = dr32(32'h5A); b32 = dr32(32'h3C); op32 = 2'b01; cin32 = 2'b01;
    in_valid32 = 1'b1;
    step();
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 40) begin step(); lat++; end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL w32_latency got %0d want 8", lat); end
    n_cmp++; if (out32 !== dr32(32'h96)) begin n_bad++; $display("FAIL w32_out got %h want %h", out32, dr32(32'h96)); end
    n_cmp++; if ({co32, ovf32, zero32} !== 4'b01_0_0) begin n_bad++; $display("FAIL w32_flags got %b want 0100", {co32, ovf32, zero32}); end
    step();
    a32 = dr32(32'h7FFF_FFFF); b32 = dr32(32'h0000_0001);
    in_valid32 = 1'b1;
    step();
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 40) begin step(); lat++; end
    n_cmp++; if (out32 !== dr32(32'h8000_0000)) begin n_bad++; $display("FAIL w32_ovf_out got %h want %h", out32, dr32(32'h8000_0000)); end
    n_cmp++; if ({out_valid32, co32, ovf32, zero32} !== 5'b1_01_1_0) begin n_bad++; $display("FAIL w32_ovf_flags got %b want 10110", {out_valid32, co32, ovf32, zero32}); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_zero();
    test_illegal();
    test_backpressure();
    test_reset_mid_run();
    test_add_w32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
